// File: rtl/button_pkg.sv
// Shared definitions for the button event block: direction codes, FSM states and the direction encoder.
// No logic latency; the helper function is purely combinational.
// No flow control here; the consumer handshake lives in button_event.
package button_pkg;

   localparam logic [1:0] DIR_NORTH = 2'd0;
   localparam logic [1:0] DIR_EAST  = 2'd1;
   localparam logic [1:0] DIR_SOUTH = 2'd2;
   localparam logic [1:0] DIR_WEST  = 2'd3;

   typedef enum logic {
      RELEASED = 1'b0,
      HELD     = 1'b1
   } state_t;

   // Fixed priority north > east > south > west; west is also the all-low fallback.
   function automatic logic [1:0] dir_encode(input logic n, input logic e, input logic s, input logic w);
      logic [1:0] d;
      d = DIR_WEST;
      if (n)      d = DIR_NORTH;
      else if (e) d = DIR_EAST;
      else if (s) d = DIR_SOUTH;
      else if (w) d = DIR_WEST;
      return d;
   endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// Small first-word fall-through event FIFO, DEPTH entries (power of two) of WIDTH bits.
// Latency: a push is visible at dat_o/empty_o in the cycle after the write edge.
// Backpressure: a push while full is accepted only together with a pop; otherwise it is ignored here.
module button_evt_fifo
   import button_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               dat_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               dat_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           full_o,
   output logic                           empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // Handshake qualification: pops need data, pushes need room (or a same-cycle pop).
   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CNT_W'(DEPTH));
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      count_o = count_q;
      dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the read port is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= dat_i;
   end

endmodule

// File: rtl/button_event.sv
// Turns debounced toggle edges plus raw direction levels into queued direction events (optional auto-repeat via BUTTON_EVENT_REPEAT_EN).
// Latency: an event pushed at the edge ending the toggle-edge cycle shows on evt_valid the next cycle.
// Backpressure: evt_valid/evt_ready pop; pushes into a full FIFO without a same-cycle pop are dropped and set sticky overflow.
module button_event
   import button_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn_toggle,
   input  logic                       btn_north,
   input  logic                       btn_east,
   input  logic                       btn_south,
   input  logic                       btn_west,
   output logic                       evt_valid,
   output logic [1:0]                 evt_dir,
   input  logic                       evt_ready,
   output logic [$clog2(DEPTH+1)-1:0] evt_count,
   output logic                       overflow
);

   state_t     state_q;
   logic [1:0] dir_q;
   logic       tog_q;
   logic       overflow_q;
   logic       edge_det;
   logic       any_btn;
   logic [1:0] dir_now;
   logic       press_push;
   logic       rep_push;
   logic       push;
   logic [1:0] push_dir;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
   logic [31:0] rep_cnt_q;
   logic        rep_first_done_q;

   // Repeat fires on the last cycle of the current hold interval; a release edge takes precedence.
   assign rep_push = (state_q == HELD) && !edge_det &&
                     (rep_cnt_q == (rep_first_done_q ? PERIOD_LAST : DELAY_LAST));
`else
   logic unused_params;
   assign unused_params = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
   assign rep_push      = 1'b0;
`endif

   // Edge detection, direction sampling and push/pop selection.
   always_comb begin
      edge_det   = btn_toggle ^ tog_q;
      any_btn    = btn_north | btn_east | btn_south | btn_west;
      dir_now    = dir_encode(btn_north, btn_east, btn_south, btn_west);
      press_push = (state_q == RELEASED) && edge_det && any_btn;
      push       = press_push | rep_push;
      push_dir   = press_push ? dir_now : dir_q;
      pop        = evt_valid & evt_ready;
   end

   // Toggle history; loading it during reset too means no spurious edge right after reset.
   always_ff @(posedge clk) begin
      tog_q <= btn_toggle;
   end

   // Press/release FSM with latched press direction and the optional repeat timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RELEASED;
         dir_q   <= DIR_NORTH;
`ifdef BUTTON_EVENT_REPEAT_EN
         rep_cnt_q        <= '0;
         rep_first_done_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            RELEASED: begin
               if (edge_det && any_btn) begin
                  state_q <= HELD;
                  dir_q   <= dir_now;
               end
            end
            HELD: begin
               if (edge_det) state_q <= RELEASED;
            end
            default: state_q <= RELEASED;
         endcase
`ifdef BUTTON_EVENT_REPEAT_EN
         if (state_q == HELD && !edge_det) begin
            if (rep_push) begin
               rep_cnt_q        <= '0;
               rep_first_done_q <= 1'b1;
            end else begin
               rep_cnt_q <= rep_cnt_q + 32'd1;
            end
         end else begin
            rep_cnt_q        <= '0;
            rep_first_done_q <= 1'b0;
         end
`endif
      end
   end

   // Sticky drop flag: only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)                            overflow_q <= 1'b0;
      else if (push && fifo_full && !pop) overflow_q <= 1'b1;
   end

   assign overflow  = overflow_q;
   assign evt_valid = ~fifo_empty;

   button_evt_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .dat_i   (push_dir),
      .pop_i   (pop),
      .dat_o   (evt_dir),
      .count_o (evt_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_button_event.sv
// Randomized plus directed bench for button_event against a queue-based press/hold model.
// Inputs change 1 time unit after the rising edge; outputs are compared there as well.
// Build with BUTTON_EVENT_REPEAT_EN defined to exercise auto-repeat expectations.
module tb_button_event;

   localparam int DEPTH  = 4;
   localparam int DELAY  = 20;
   localparam int PERIOD = 5;
   localparam int CW     = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_toggle = 1'b0;
   logic          btn_north = 1'b0, btn_east = 1'b0, btn_south = 1'b0, btn_west = 1'b0;
   logic          evt_valid;
   logic [1:0]    evt_dir;
   logic          evt_ready = 1'b0;
   logic [CW-1:0] evt_count;
   logic          overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [1:0] mq[$];
   logic       m_ovf     = 1'b0;
   logic       m_pressed = 1'b0;
   logic [1:0] m_dir     = 2'd0;
   logic       m_tog     = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
   int         m_hold    = 0;
`endif
   logic       tog       = 1'b0;

   always #5 clk = ~clk;

   button_event #(
      .DEPTH         (DEPTH),
      .REPEAT_DELAY  (DELAY),
      .REPEAT_PERIOD (PERIOD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_toggle (btn_toggle),
      .btn_north  (btn_north),
      .btn_east   (btn_east),
      .btn_south  (btn_south),
      .btn_west   (btn_west),
      .evt_valid  (evt_valid),
      .evt_dir    (evt_dir),
      .evt_ready  (evt_ready),
      .evt_count  (evt_count),
      .overflow   (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // b = {north, east, south, west}; the first set bit from the north end wins
   function automatic logic [1:0] prio(input logic [3:0] b);
      for (int i = 3; i >= 0; i--)
         if (b[i]) return 2'(3 - i);
      return 2'd3;
   endfunction

   // Model update for one clock edge, using the inputs held during the cycle.
   task automatic model_edge(input logic [3:0] b);
      logic ev;
      logic p;
      if (rst) begin
         mq.delete();
         m_ovf     = 1'b0;
         m_pressed = 1'b0;
         m_tog     = btn_toggle;
      end else begin
         ev    = (btn_toggle != m_tog);
         m_tog = btn_toggle;
         p     = 1'b0;
         if (ev) begin
            if (!m_pressed && b != 4'b0) begin
               m_pressed = 1'b1;
               m_dir     = prio(b);
               p         = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
               m_hold    = 0;
`endif
            end else if (m_pressed) begin
               m_pressed = 1'b0;
            end
         end else if (m_pressed) begin
`ifdef BUTTON_EVENT_REPEAT_EN
            m_hold++;
            if (m_hold >= DELAY && ((m_hold - DELAY) % PERIOD) == 0) p = 1'b1;
`endif
         end
         if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
         if (p) begin
            if (mq.size() < DEPTH) mq.push_back(m_dir);
            else                   m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic t, input logic [3:0] b, input logic r, input logic rs);
      btn_toggle = t;
      {btn_north, btn_east, btn_south, btn_west} = b;
      evt_ready = r;
      rst = rs;
      @(posedge clk);
      model_edge(b);
      #1;
      chk("valid", 32'(evt_valid), 32'(mq.size() > 0));
      chk("count", 32'(evt_count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) chk("dir", 32'(evt_dir), 32'(mq[0]));
      if (rs)            chk("rst_dir", 32'(evt_dir), 32'd0);
   endtask

   task automatic do_reset();
      repeat (3) step(tog, 4'b0, 1'b0, 1'b1);
   endtask

   task automatic press(input logic [3:0] b, input int hold, input logic r);
      tog = ~tog;
      step(tog, b, r, 1'b0);
      repeat (hold) step(tog, b, r, 1'b0);
      tog = ~tog;
      step(tog, 4'b0, r, 1'b0);
      step(tog, 4'b0, r, 1'b0);
   endtask

   initial begin
      logic [1:0] order [5];
      logic [3:0] pat   [5];
      #1;
      // reset state
      do_reset();
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_count", 32'(evt_count), 32'd0);

      // single east press: valid right after the edge cycle's clock edge
      repeat (9) step(tog, 4'b0100, 1'b0, 1'b0);
      chk("east_pre_valid", 32'(evt_valid), 32'd0);
      tog = 1'b1;
      step(tog, 4'b0100, 1'b0, 1'b0);
      chk("east_valid", 32'(evt_valid), 32'd1);
      chk("east_dir", 32'(evt_dir), 32'd1);
      chk("east_count", 32'(evt_count), 32'd1);
      tog = 1'b0;
      step(tog, 4'b0, 1'b0, 1'b0);
      chk("east_release_count", 32'(evt_count), 32'd1);
      step(tog, 4'b0, 1'b1, 1'b0);
      chk("east_popped", 32'(evt_valid), 32'd0);

      // north + west together -> north; release adds nothing
      press(4'b1001, 2, 1'b0);
      chk("nw_dir", 32'(evt_dir), 32'd0);
      chk("nw_count", 32'(evt_count), 32'd1);

      // five presses into DEPTH=4 with no consumer
      do_reset();
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b1000; pat[3] = 4'b0110; pat[4] = 4'b0100;
      order[0] = 2'd3;  order[1] = 2'd2;  order[2] = 2'd0;  order[3] = 2'd1;
      for (int i = 0; i < 5; i++) press(pat[i], 2, 1'b0);
      chk("full_count", 32'(evt_count), 32'd4);
      chk("full_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_dir", 32'(evt_dir), 32'(order[i]));
         step(tog, 4'b0, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(evt_valid), 32'd0);
      step(tog, 4'b0, 1'b1, 1'b0);
      chk("empty_ready_count", 32'(evt_count), 32'd0);
      chk("overflow_sticky", 32'(overflow), 32'd1);

      // full FIFO with a simultaneous pop accepts the push
      do_reset();
      for (int i = 0; i < 4; i++) press(pat[i], 2, 1'b0);
      tog = ~tog;
      step(tog, 4'b0010, 1'b1, 1'b0);
      chk("push_pop_count", 32'(evt_count), 32'd4);
      chk("push_pop_overflow", 32'(overflow), 32'd0);
      chk("push_pop_head", 32'(evt_dir), 32'd2);
      tog = ~tog;
      step(tog, 4'b0, 1'b0, 1'b0);

      // resync edge with nothing pressed, then a real press
      do_reset();
      tog = ~tog;
      step(tog, 4'b0, 1'b0, 1'b0);
      step(tog, 4'b0, 1'b0, 1'b0);
      chk("resync_count", 32'(evt_count), 32'd0);
      press(4'b0010, 2, 1'b0);
      chk("after_resync_count", 32'(evt_count), 32'd1);
      chk("after_resync_dir", 32'(evt_dir), 32'd2);

      // reset mid-press: the later release edge is absorbed
      tog = ~tog;
      step(tog, 4'b0100, 1'b0, 1'b0);
      repeat (2) step(tog, 4'b0100, 1'b0, 1'b1);
      tog = ~tog;
      step(tog, 4'b0, 1'b0, 1'b0);
      step(tog, 4'b0, 1'b0, 1'b0);
      chk("midreset_count", 32'(evt_count), 32'd0);
      press(4'b1000, 2, 1'b0);
      chk("midreset_press_count", 32'(evt_count), 32'd1);

      // long south hold
      do_reset();
      press(4'b0010, 34, 1'b0);
      repeat (10) step(tog, 4'b0, 1'b0, 1'b0);
`ifdef BUTTON_EVENT_REPEAT_EN
      chk("repeat_count", 32'(evt_count), 32'd4);
`else
      chk("norepeat_count", 32'(evt_count), 32'd1);
`endif
      chk("hold_overflow", 32'(overflow), 32'd0);
      chk("hold_dir", 32'(evt_dir), 32'd2);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] b;
         logic       rs;
         b  = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
         rs = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) tog = ~tog;
         step(tog, b, ($urandom_range(0, 2) == 0), rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
